// File: rtl/prog_loader_mem.sv
// Byte-addressed program memory with a byte-serial image loader that holds the core in reset until loaded.
// Optional checksum byte after the image: define PROG_CHECKSUM_EN.
module prog_loader_mem #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_start,
    input  logic                ld_valid,
    input  logic [DATA_W-1:0]   ld_data,
    output logic                ld_ready,
    input  logic [ADDR_W-1:0]   add,
    output logic [4*DATA_W-1:0] inst,
    output logic                rst_cpu,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

`ifdef PROG_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_RUN} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic                rst_cpu_q, rst_cpu_d;
    logic                ld_ready_q, ld_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                accept;

`ifdef PROG_CHECKSUM_EN
    logic [7:0]          sum_q, sum_d;
    logic [7:0]          sum_next;
    logic                err_q, err_d;
`endif

    // ld_ready_q is only ever high in LOAD/CHECK, so it qualifies every transfer.
    assign accept = ld_valid && ld_ready_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mem_d   = mem_q;
`ifdef PROG_CHECKSUM_EN
        sum_d    = sum_q;
        err_d    = err_q;
        sum_next = sum_q + ld_data;
`endif
        case (state_q)
            S_IDLE, S_RUN: begin
                if (ld_start) begin
                    state_d = S_LOAD;
                    count_d = '0;
`ifdef PROG_CHECKSUM_EN
                    sum_d = '0;
                    err_d = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (accept) begin
                    mem_d[count_q[ADDR_W-1:0]] = ld_data;
                    count_d = count_q + 1'b1;
`ifdef PROG_CHECKSUM_EN
                    sum_d = sum_next;
                    if (count_q == LAST_IDX) state_d = S_CHECK;
`else
                    if (count_q == LAST_IDX) state_d = S_RUN;
`endif
                end
            end
`ifdef PROG_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    if (sum_next == 8'h00) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        rst_cpu_d = (state_d != S_RUN);
`ifdef PROG_CHECKSUM_EN
        ld_ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
`else
        ld_ready_d = (state_d == S_LOAD);
`endif
        busy_d = ld_ready_d;
        done_d = (state_d == S_RUN) && (state_q != S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            rst_cpu_q  <= 1'b1;
            ld_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef PROG_CHECKSUM_EN
            sum_q <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rst_cpu_q  <= rst_cpu_d;
            ld_ready_q <= ld_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_q      <= mem_d;
`ifdef PROG_CHECKSUM_EN
            sum_q <= sum_d;
            err_q <= err_d;
`endif
        end
    end

    // Big-endian fetch window; byte indices wrap naturally in ADDR_W bits.
    logic [ADDR_W-1:0] a1, a2, a3;
    assign a1   = add + ADDR_W'(1);
    assign a2   = add + ADDR_W'(2);
    assign a3   = add + ADDR_W'(3);
    assign inst = {mem_q[add], mem_q[a1], mem_q[a2], mem_q[a3]};

    assign rst_cpu  = rst_cpu_q;
    assign ld_ready = ld_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef PROG_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader_mem.sv
// Randomized bench for prog_loader_mem against a byte-array reference model.
module tb_prog_loader_mem;
    logic        clk;
    logic        rst;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic [4:0]  add;
    logic [31:0] inst;
    logic        rst_cpu;
    logic        busy;
    logic        done;
    logic        err;

    prog_loader_mem #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_ready(ld_ready), .add(add), .inst(inst),
        .rst_cpu(rst_cpu), .busy(busy), .done(done), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] model_mem [32];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_inst(input int a);
        return {model_mem[a % 32], model_mem[(a + 1) % 32],
                model_mem[(a + 2) % 32], model_mem[(a + 3) % 32]};
    endfunction

    function automatic logic [7:0] model_sum();
        int s = 0;
        for (int i = 0; i < 32; i++) s += model_mem[i];
        return 8'(s);
    endfunction

    // Only called while memory is stable (IDLE/RUN).
    task automatic check_fetch(input int n);
        for (int k = 0; k < n; k++) begin
            int a = $urandom_range(0, 31);
            add = 5'(a);
            #1;
            check("fetch", inst, model_inst(a));
        end
    endtask

    task automatic check_const(input int a, input logic [31:0] exp);
        add = 5'(a);
        #1;
        check("fetch_const", inst, exp);
    endtask

    // mode 0: back-to-back, 1: valid every other cycle (starting low), 2: random gaps.
    // abort_at > 0 asserts rst once that many bytes have been accepted.
    task automatic load_image(input logic [7:0] img [32], input int mode, input bit start_valid,
                              input int abort_at, input logic [7:0] csum, output int cycles);
        int  i = 0;
        bit  v;
        bit  tog = 1'b0;
        cycles = 0;
        @(negedge clk);
        ld_start = 1'b1;
        ld_valid = start_valid;
        ld_data  = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        ld_start = 1'b0;
        ld_valid = 1'b0;
        check("start_rst_cpu", 32'(rst_cpu), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_ld_ready", 32'(ld_ready), 32'd1);
        check("start_err", 32'(err), 32'd0);
        while (i < 32 && cycles < 500) begin
            if (abort_at > 0 && i == abort_at) begin
                ld_valid = 1'b0;
                rst = 1'b1;
                for (int j = 0; j < 32; j++) model_mem[j] = 8'h00;
                #1;
                check("abort_rst_cpu", 32'(rst_cpu), 32'd1);
                check("abort_ld_ready", 32'(ld_ready), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                for (int a = 0; a < 32; a++) check_const(a, 32'h0);
                @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            case (mode)
                0: v = 1'b1;
                1: begin v = tog; tog = ~tog; end
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            ld_valid = v;
            ld_data  = img[i];
            @(posedge clk);
            cycles++;
            if (v) begin
                model_mem[i] = img[i];
                i++;
            end
            @(negedge clk);
            ld_valid = 1'b0;
            if (v && i < 32) begin
                int a = $urandom_range(0, 31);
                add = 5'(a);
                #1;
                check("midload_fetch", inst, model_inst(a));
                check("midload_rst_cpu", 32'(rst_cpu), 32'd1);
            end
        end
        if (cycles >= 500) begin
            check("load_timeout", 32'd0, 32'd1);
            return;
        end
`ifdef PROG_CHECKSUM_EN
        begin
            bit ok;
            check("chk_ld_ready", 32'(ld_ready), 32'd1);
            check("chk_done", 32'(done), 32'd0);
            ok = (8'(model_sum() + csum) == 8'h00);
            ld_valid = 1'b1;
            ld_data  = csum;
            @(posedge clk);
            @(negedge clk);
            ld_valid = 1'b0;
            if (!ok) begin
                check("fail_err", 32'(err), 32'd1);
                check("fail_rst_cpu", 32'(rst_cpu), 32'd1);
                check("fail_busy", 32'(busy), 32'd0);
                check("fail_done", 32'(done), 32'd0);
                check("fail_ld_ready", 32'(ld_ready), 32'd0);
                @(negedge clk);
                check("fail_err_sticky", 32'(err), 32'd1);
                return;
            end
        end
`endif
        check("done_pulse", 32'(done), 32'd1);
        check("run_rst_cpu", 32'(rst_cpu), 32'd0);
        check("run_busy", 32'(busy), 32'd0);
        check("run_ld_ready", 32'(ld_ready), 32'd0);
        check("run_err", 32'(err), 32'd0);
        @(negedge clk);
        check("done_once", 32'(done), 32'd0);
        check("run_rst_cpu_hold", 32'(rst_cpu), 32'd0);
    endtask

    logic [7:0] img [32];
    int         cyc;

    function automatic logic [7:0] good_csum();
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 32; i++) s = s + img[i];
        return 8'(8'h00 - s);
    endfunction

    initial begin
        rst = 1'b1;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data = 8'h00;
        add = 5'd0;
        for (int j = 0; j < 32; j++) model_mem[j] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rst_cpu", 32'(rst_cpu), 32'd1);
        check("reset_ld_ready", 32'(ld_ready), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check_const(0, 32'h0);
        check_const(31, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_rst_cpu", 32'(rst_cpu), 32'd1);

        // Ascending image, back-to-back
        for (int j = 0; j < 32; j++) img[j] = 8'(j);
        load_image(img, 0, 1'b0, 0, good_csum(), cyc);
        check_const(8, 32'h08090A0B);
        check_const(30, 32'h1E1F0001);
        check("cycles_b2b", 32'(cyc), 32'd32);

        // Same image, valid toggling
        load_image(img, 1, 1'b0, 0, good_csum(), cyc);
        check("cycles_toggle", 32'(cyc), 32'd64);
        check_const(8, 32'h08090A0B);
        check_const(30, 32'h1E1F0001);

        // Reset after 10 accepted bytes, then full reload
        for (int j = 0; j < 32; j++) img[j] = 8'($urandom);
        load_image(img, 0, 1'b0, 10, good_csum(), cyc);
        @(negedge clk);
        check("post_abort_rst_cpu", 32'(rst_cpu), 32'd1);
        check("post_abort_done", 32'(done), 32'd0);
        load_image(img, 2, 1'b0, 0, good_csum(), cyc);
        check_fetch(6);

        // Reload from RUN with descending image, ld_valid asserted alongside ld_start
        for (int j = 0; j < 32; j++) img[j] = 8'(8'hFF - j);
        load_image(img, 0, 1'b1, 0, good_csum(), cyc);
        check_const(0, 32'hFFFEFDFC);
        check_fetch(4);

`ifdef PROG_CHECKSUM_EN
        for (int j = 0; j < 32; j++) img[j] = 8'(j);
        load_image(img, 0, 1'b0, 0, 8'h10, cyc);
        check_const(8, 32'h08090A0B);
        load_image(img, 0, 1'b0, 0, 8'h11, cyc);
        check_fetch(3);
        load_image(img, 2, 1'b0, 0, 8'h10, cyc);
`endif

        // Random images, gaps and start collisions
        for (int r = 0; r < 5; r++) begin
            logic [7:0] c;
            for (int j = 0; j < 32; j++) img[j] = 8'($urandom);
            c = good_csum();
            if ($urandom_range(0, 3) == 0) c = c + 8'(1 + $urandom_range(0, 254));
            load_image(img, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, c, cyc);
            check_fetch(5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=%0d expected=finish", checks);
        $fatal(1, "timeout");
    end
endmodule
